// File: rtl/vend_ctrl.sv
// Vending sequencer: coin credit, priced selection, dispense handshake and unit change return.
// Optional VEND_CTRL_TIMEOUT_REFUND_EN adds an inactivity auto-refund after TIMEOUT cycles.
module vend_ctrl #(
  parameter int unsigned PRICE0   = 3,
  parameter int unsigned PRICE1   = 4,
  parameter int unsigned PRICE2   = 5,
  parameter int unsigned PRICE3   = 6,
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned TIMEOUT  = 1000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          coin_in,
  input  logic                sel_valid,
  input  logic [1:0]          sel,
  input  logic                cancel,
  input  logic                dispense_ready,
  output logic                dispense_valid,
  output logic [1:0]          dispense_id,
  output logic                change_out,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_rej,
  output logic                busy
);

  localparam int unsigned SumW = CREDIT_W + 1;

  typedef enum logic [1:0] {StIdle, StCredit, StVend, StChange} state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [1:0]          id_q, id_d;
  logic                rej_q, rej_d;
  logic [CREDIT_W-1:0] price;
  logic                coin_ok;
  logic [SumW-1:0]     coin_sum;
  logic                coin_fits;
  logic                activity;
  logic                timeout_hit;

  always_comb begin
    price = '0;
    unique case (sel)
      2'd0: price = CREDIT_W'(PRICE0);
      2'd1: price = CREDIT_W'(PRICE1);
      2'd2: price = CREDIT_W'(PRICE2);
      2'd3: price = CREDIT_W'(PRICE3);
    endcase
  end

  assign coin_ok   = (coin_in == 2'b01) || (coin_in == 2'b10);
  // One extra bit so the overflow test sees the carry.
  assign coin_sum  = {1'b0, credit_q} + SumW'(coin_in);
  assign coin_fits = coin_sum <= {1'b0, {CREDIT_W{1'b1}}};
  assign activity  = (coin_in != 2'b00) || sel_valid || cancel;

`ifdef VEND_CTRL_TIMEOUT_REFUND_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;

  assign timeout_hit = (state_q == StCredit) && !activity && (idle_cnt_q == CntW'(TIMEOUT - 1));

  always_comb begin
    idle_cnt_d = '0;
    if ((state_q == StCredit) && (state_d == StCredit) && !activity) begin
      idle_cnt_d = idle_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    id_d     = id_q;
    rej_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (coin_ok && coin_fits) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          state_d  = StCredit;
        end else if (coin_in != 2'b00) begin
          rej_d = 1'b1;
        end
      end
      StCredit: begin
        if (cancel || timeout_hit) begin
          state_d = StChange;
          rej_d   = coin_in != 2'b00;
        end else if (sel_valid && (credit_q >= price)) begin
          credit_d = credit_q - price;
          id_d     = sel;
          state_d  = StVend;
          rej_d    = coin_in != 2'b00;
        end else if (coin_ok && coin_fits) begin
          credit_d = coin_sum[CREDIT_W-1:0];
        end else if (coin_in != 2'b00) begin
          rej_d = 1'b1;
        end
      end
      StVend: begin
        rej_d = coin_in != 2'b00;
        if (dispense_ready) begin
          state_d = (credit_q != '0) ? StChange : StIdle;
        end
      end
      StChange: begin
        rej_d = coin_in != 2'b00;
        if (credit_q != '0) begin
          credit_d = credit_q - CREDIT_W'(1);
          if (credit_q == CREDIT_W'(1)) begin
            state_d = StIdle;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      credit_q <= '0;
      id_q     <= '0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      id_q     <= id_d;
      rej_q    <= rej_d;
    end
  end

  assign dispense_valid = state_q == StVend;
  assign dispense_id    = id_q;
  assign change_out     = (state_q == StChange) && (credit_q != '0);
  assign credit         = credit_q;
  assign coin_rej       = rej_q;
  assign busy           = (state_q == StVend) || (state_q == StChange);

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: directed scenarios plus random traffic against a credit model.
module tb_vend_ctrl;

  localparam int unsigned CW     = 4;
  localparam int unsigned TO     = 8;
  localparam int          MaxCr  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    coin_in = 2'b00;
  logic          sel_valid = 1'b0;
  logic [1:0]    sel = 2'b00;
  logic          cancel = 1'b0;
  logic          dispense_ready = 1'b0;
  logic          dispense_valid;
  logic [1:0]    dispense_id;
  logic          change_out;
  logic [CW-1:0] credit;
  logic          coin_rej;
  logic          busy;

  int n_pass  = 0;
  int n_total = 0;

  int prices[4] = '{3, 4, 5, 6};

  // Model: credit amount plus "item pending" and "refunding" flags.
  int m_credit = 0;
  bit m_vend   = 0;
  bit m_ref    = 0;
  bit m_rej    = 0;
  int m_id     = 0;
  int m_idle   = 0;

  always #5 clk = ~clk;

  vend_ctrl #(
    .CREDIT_W(CW),
    .TIMEOUT (TO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .coin_in       (coin_in),
    .sel_valid     (sel_valid),
    .sel           (sel),
    .cancel        (cancel),
    .dispense_ready(dispense_ready),
    .dispense_valid(dispense_valid),
    .dispense_id   (dispense_id),
    .change_out    (change_out),
    .credit        (credit),
    .coin_rej      (coin_rej),
    .busy          (busy)
  );

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge reset_n) begin : model
    int cr;
    int id;
    int idl;
    int c;
    bit vd;
    bit rf;
    bit rj;
    if (!reset_n) begin
      m_credit <= 0;
      m_vend   <= 0;
      m_ref    <= 0;
      m_rej    <= 0;
      m_id     <= 0;
      m_idle   <= 0;
    end else begin
      cr  = m_credit;
      vd  = m_vend;
      rf  = m_ref;
      id  = m_id;
      idl = m_idle;
      rj  = 0;
      c   = int'(coin_in);
      if (vd) begin
        rj = c != 0;
        if (dispense_ready) begin
          vd = 0;
          rf = cr > 0;
        end
      end else if (rf) begin
        rj = c != 0;
        if (cr > 0) cr--;
        if (cr == 0) rf = 0;
      end else if (cr == 0) begin
        if (c == 3) rj = 1;
        else if (c != 0) begin
          if (c > MaxCr) rj = 1;
          else cr = c;
        end
      end else begin
        if (cancel) begin
          rf = 1;
          rj = c != 0;
        end else if (sel_valid && cr >= prices[sel]) begin
          cr = cr - prices[sel];
          vd = 1;
          id = int'(sel);
          rj = c != 0;
        end else begin
          if (c == 3) rj = 1;
          else if (c != 0) begin
            if (cr + c > MaxCr) rj = 1;
            else cr = cr + c;
          end
`ifdef VEND_CTRL_TIMEOUT_REFUND_EN
          if (c != 0 || sel_valid) idl = 0;
          else if (idl == TO - 1) begin
            rf  = 1;
            idl = 0;
          end else idl++;
`endif
        end
      end
      if (vd || rf || cr == 0) idl = 0;
      m_credit <= cr;
      m_vend   <= vd;
      m_ref    <= rf;
      m_rej    <= rj;
      m_id     <= id;
      m_idle   <= idl;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("dispense_valid", dispense_valid, m_vend);
      check("change_out", change_out, (m_ref && m_credit > 0));
      check("credit", credit, m_credit);
      check("coin_rej", coin_rej, m_rej);
      check("busy", busy, (m_vend || m_ref));
      if (m_vend) check("dispense_id", dispense_id, m_id);
    end
  end

  task automatic step(input logic [1:0] c, input logic sv, input logic [1:0] s,
                      input logic can, input logic rdy);
    coin_in        = c;
    sel_valid      = sv;
    sel            = s;
    cancel         = can;
    dispense_ready = rdy;
    @(posedge clk);
    @(negedge clk);
    #1;
    coin_in        = 2'b00;
    sel_valid      = 1'b0;
    cancel         = 1'b0;
    dispense_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(2'b00, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic count_pulses(input int maxc, output int n);
    n = 0;
    repeat (maxc) begin
      if (change_out) n++;
      idle(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r;
    repeat (3) @(negedge clk);
    #1;
    check("reset dispense_valid", dispense_valid, 0);
    check("reset change_out", change_out, 0);
    check("reset credit", credit, 0);
    check("reset busy", busy, 0);
    reset_n = 1'b1;

    // 4 units, exact price of product 1.
    step(2'b01, 0, 0, 0, 0); check("coin1 credit", credit, 1);
    step(2'b10, 0, 0, 0, 0); check("coin2 credit", credit, 3);
    step(2'b01, 0, 0, 0, 0); check("coin3 credit", credit, 4);
    step(2'b00, 1, 1, 0, 0);
    check("t1 valid", dispense_valid, 1);
    check("t1 id", dispense_id, 1);
    check("t1 credit", credit, 0);
    step(2'b00, 0, 0, 0, 1);
    check("t1 valid drop", dispense_valid, 0);
    check("t1 busy", busy, 0);
    count_pulses(5, n);
    check("t1 pulses", n, 0);

    // 5 units, product 0 leaves 2 units change.
    step(2'b10, 0, 0, 0, 0);
    step(2'b10, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0);
    step(2'b00, 1, 0, 0, 0);
    check("t2 credit", credit, 2);
    check("t2 valid", dispense_valid, 1);
    step(2'b00, 0, 0, 0, 1);
    count_pulses(8, n);
    check("t2 pulses", n, 2);
    check("t2 credit end", credit, 0);

    // Insufficient credit, then cancel.
    step(2'b10, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0);
    step(2'b00, 1, 3, 0, 0);
    check("t3 ignored valid", dispense_valid, 0);
    check("t3 credit", credit, 3);
    step(2'b00, 0, 0, 1, 0);
    count_pulses(8, n);
    check("t3 pulses", n, 3);

    // Rejections.
    step(2'b01, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0);
    check("t4 invalid rej", coin_rej, 1);
    check("t4 invalid credit", credit, 1);
    repeat (6) step(2'b10, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0);
    check("t4 credit 14", credit, 14);
    step(2'b10, 0, 0, 0, 0);
    check("t4 overflow rej", coin_rej, 1);
    check("t4 overflow credit", credit, 14);
    step(2'b00, 1, 2, 0, 0);
    check("t4 vend credit", credit, 9);
    step(2'b01, 0, 0, 0, 0);
    check("t4 vend rej", coin_rej, 1);
    check("t4 vend rej credit", credit, 9);
    for (int i = 0; i < 20; i++) begin
      idle(1);
      check("hold valid", dispense_valid, 1);
      check("hold id", dispense_id, 2);
    end
    step(2'b00, 0, 0, 0, 1);
    check("t5 change start", change_out, 1);
    idle(2);
    check("t5 credit mid", credit, 7);
    #2;
    reset_n = 1'b0;
    #1;
    check("async valid", dispense_valid, 0);
    check("async change_out", change_out, 0);
    check("async credit", credit, 0);
    check("async busy", busy, 0);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    idle(2);

    // Inactivity behaviour.
    step(2'b10, 0, 0, 0, 0);
`ifdef VEND_CTRL_TIMEOUT_REFUND_EN
    idle(7);
    check("to before busy", busy, 0);
    check("to before credit", credit, 2);
    idle(1);
    check("to busy", busy, 1);
    count_pulses(8, n);
    check("to pulses", n, 2);
`else
    idle(100);
    check("hold credit", credit, 2);
    check("hold busy", busy, 0);
    check("hold change", change_out, 0);
    step(2'b00, 0, 0, 1, 0);
    idle(4);
`endif

    // Random traffic.
    repeat (3000) begin
      r = $urandom_range(0, 9);
      step((r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11,
           ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vend_ctrl.md
# vend_ctrl

Sequencing controller for the vending machine datapath: accumulates coin credit, arbitrates product selection against four configurable prices, runs a dispense handshake with the delivery mechanism and returns change one unit per cycle. It sits between the coin acceptor / keypad front end and the dispense mechanism, and is the single owner of the credit register. Credit is counted in coin units, where 1 unit = 5.

## Interface
- PRICE0, default 3, price of product 0 in units
- PRICE1, default 4, price of product 1 in units
- PRICE2, default 5, price of product 2 in units
- PRICE3, default 6, price of product 3 in units
- CREDIT_W, default 4, credit register width; maximum credit is 2^CREDIT_W-1
- TIMEOUT, default 1000, inactivity cycles before auto-refund; used only with the macro

- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- coin_in  input  2  00 none, 01 = 1 unit, 10 = 2 units, 11 = invalid coin
- sel_valid  input  1  product select strobe
- sel  input  2  product index
- cancel  input  1  refund request
- dispense_ready  input  1  mechanism accepts the item
- dispense_valid  output  1  item request pending
- dispense_id  output  2  product being dispensed
- change_out  output  1  one-unit change pulse
- credit  output  CREDIT_W  current credit
- coin_rej  output  1  coin-rejected pulse
- busy  output  1  high in VEND or CHANGE

## Operation
- States: IDLE (credit 0), CREDIT, VEND, CHANGE. Reset forces IDLE, and all outputs go to 0 while reset_n is low, independent of clk.
- IDLE:
  - A valid coin adds its units and moves to CREDIT.
  - sel_valid and cancel are ignored.
- CREDIT, evaluated in this priority order each cycle:
  1. cancel moves to CHANGE.
  2. sel_valid with credit >= PRICE[sel] subtracts the price, latches dispense_id = sel and moves to VEND.
  3. sel_valid with insufficient credit is ignored; state and credit are unchanged.
  4. A valid coin is added.
- If cancel or an accepted select occurs in the same cycle as a coin, that coin is rejected.
- A coin is rejected with coin_rej pulsed for 1 cycle and credit unchanged in any of these cases:
  - coin_in = 11 in any state
  - a coin would overflow 2^CREDIT_W-1
  - any coin arrives in VEND or CHANGE
- VEND:
  - dispense_valid = 1; dispense_id is held stable.
  - dispense_valid and dispense_id must not change until dispense_ready = 1 is sampled.
  - On the handshake, move to CHANGE if credit > 0, otherwise to IDLE.
  - cancel and sel_valid are ignored.
- CHANGE:
  - change_out = 1 and credit decrements by 1 every cycle.
  - When credit reaches 0, return to IDLE, with change_out low from that cycle onward.
  - If CHANGE is entered with credit 0 (cancel at 0, impossible in CREDIT but defined), go straight to IDLE with no pulse.
- Arithmetic is unsigned, CREDIT_W bits; the compare uses the full width. A price wider than CREDIT_W is a configuration error.

## Timing
- All outputs are registered and update on the rising edge after the sampled input.
- Coin latency: credit reflects a coin 1 cycle after it is sampled.
- Select latency: dispense_valid rises 1 cycle after an accepted sel_valid, and credit already shows the post-price value in that same cycle.
- Handshake: the transfer occurs on the cycle where dispense_valid && dispense_ready; dispense_valid drops on the next cycle.
- Change of N units: change_out is high for exactly N consecutive cycles, starting the cycle after entry to CHANGE.
- busy equals (state == VEND or state == CHANGE), registered.
- Reset mid-VEND or mid-CHANGE: dispense_valid, change_out and credit drop asynchronously; the remaining credit is lost. This is intentional.

## Configuration
- VEND_CTRL_TIMEOUT_REFUND_EN defined:
  - A cycle counter runs in CREDIT. It clears on any coin, sel_valid or cancel, and on leaving CREDIT.
  - When the count reaches TIMEOUT-1 with no activity, the FSM moves to CHANGE as if cancel had been asserted.
- Not defined: no counter is present, and CREDIT waits indefinitely.

## Test plan
- Reset, then coins 01, 10, 01 (4 units), then sel=1 -> dispense_valid high with id=1, credit=0; after dispense_ready, return to IDLE with no change_out pulses.
- Credit 5, sel=0 (price 3) -> credit=2, VEND, then after handshake exactly 2 change_out cycles, credit=0, IDLE.
- Credit 3, sel=3 (price 6) -> ignored, stays in CREDIT with credit=3; then cancel -> 3 change_out pulses.
- coin_in=11 in CREDIT, a coin 10 at credit 14, and coin 01 during VEND -> each gives a 1-cycle coin_rej pulse with credit unchanged.
- Hold dispense_ready=0 for 20 cycles in VEND -> dispense_valid and dispense_id stable throughout; reset_n low mid-CHANGE -> all outputs 0 immediately.
- With VEND_CTRL_TIMEOUT_REFUND_EN and TIMEOUT=8: credit 2, then idle -> CHANGE entered after 8 idle cycles, followed by 2 change_out pulses. Without the macro, the bench holds in CREDIT for 100 cycles.
